// File: rtl/conv_1d_pkg.sv
// Shared types and constants for the conv_1d stream path.
package conv_1d_pkg;

  localparam int unsigned CONV_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/conv_1d_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible while the FIFO is not empty.
module conv_1d_fifo
  import conv_1d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/conv_1d_stream_tx.sv
// Frames samples from a local FIFO into a valid/ready stream toward conv_1d,
// emitting frame_len samples per start request with last/done marking.
module conv_1d_stream_tx
  import conv_1d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_vld,
  output logic                    wr_rdy,
  input  logic [LEN_WIDTH-1:0]    frame_len,
  input  logic                    start,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   signal_data,
  output logic                    signal_vld,
  output logic                    signal_last,
  input  logic                    signal_rdy,
  output logic                    frame_done,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  tx_state_t             state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  frame_done_q, frame_done_d;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign wr_rdy     = !fifo_full;
  assign fifo_push  = wr_vld && !fifo_full;
  assign busy       = (state_q == SEND);
  assign frame_done = frame_done_q;

  conv_1d_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head      (signal_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Stream outputs depend only on flops, so they hold steady under backpressure.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    frame_done_d = 1'b0;
    signal_vld   = 1'b0;
    signal_last  = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d     = SEND;
          remaining_d = frame_len;
        end
      end
      SEND: begin
        signal_vld  = !fifo_empty;
        signal_last = signal_vld && (remaining_q == LEN_WIDTH'(1));
        fifo_pop    = signal_vld && signal_rdy;
        if (fifo_pop) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (signal_last) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_conv_1d_stream_tx.sv
// Randomized and directed bench for conv_1d_stream_tx against a queue-based frame model.
module tb_conv_1d_stream_tx;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_vld;
  logic          wr_rdy;
  logic [LW-1:0] frame_len;
  logic          start;
  logic          busy;
  logic [DW-1:0] signal_data;
  logic          signal_vld;
  logic          signal_last;
  logic          signal_rdy;
  logic          frame_done;
  logic [CW-1:0] fifo_count;

  conv_1d_stream_tx #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_vld      (wr_vld),
    .wr_rdy      (wr_rdy),
    .frame_len   (frame_len),
    .start       (start),
    .busy        (busy),
    .signal_data (signal_data),
    .signal_vld  (signal_vld),
    .signal_last (signal_last),
    .signal_rdy  (signal_rdy),
    .frame_done  (frame_done),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: samples held in a queue, frame progress as a plain countdown.
  logic [DW-1:0] m_q[$];
  bit            m_busy;
  int            m_rem;
  bit            m_done;

  logic [DW-1:0] got[$];
  int            busy_cycles;
  int            done_pulses;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare outputs against the model, then advance one clock and update the model.
  task automatic tick();
    bit exp_vld, exp_last, xfer, load, last_xfer;
    exp_vld  = m_busy && (m_q.size() > 0);
    exp_last = exp_vld && (m_rem == 1);
    check_val("wr_rdy",      32'(wr_rdy),      32'(m_q.size() < DEPTH));
    check_val("fifo_count",  32'(fifo_count),  32'(m_q.size()));
    check_val("busy",        32'(busy),        32'(m_busy));
    check_val("signal_vld",  32'(signal_vld),  32'(exp_vld));
    check_val("signal_last", 32'(signal_last), 32'(exp_last));
    check_val("frame_done",  32'(frame_done),  32'(m_done));
    if (exp_vld) check_val("signal_data", 32'(signal_data), 32'(m_q[0]));
    if (busy) busy_cycles++;
    if (frame_done) done_pulses++;
    if (signal_vld && signal_rdy && !rst) got.push_back(signal_data);

    xfer      = exp_vld && signal_rdy;
    load      = wr_vld && (m_q.size() < DEPTH);
    last_xfer = xfer && exp_last;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_busy = 1'b0;
      m_rem  = 0;
      m_done = 1'b0;
    end else begin
      bit was_busy;
      was_busy = m_busy;
      if (xfer) begin
        void'(m_q.pop_front());
        m_rem--;
        if (last_xfer) m_busy = 1'b0;
      end
      if (load) m_q.push_back(wr_data);
      if (!was_busy && start && frame_len != '0) begin
        m_busy = 1'b1;
        m_rem  = int'(frame_len);
      end
      m_done = last_xfer;
    end
    #1;
  endtask

  task automatic load_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_vld  = 1'b1;
      wr_data = DW'(first + i);
      tick();
    end
    wr_vld = 1'b0;
  endtask

  task automatic start_frame(input int len);
    frame_len = LW'(len);
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_got(input string tag, input int first, input int n);
    check_val({tag, "_len"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check_val({tag, "_order"}, 32'(got[i]), 32'(first + i));
    got.delete();
  endtask

  task automatic basic_frame(input string tag);
    load_seq(1, 4);
    busy_cycles = 0;
    done_pulses = 0;
    got.delete();
    start_frame(4);
    repeat (6) tick();
    check_val({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd4);
    check_val({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
    check_got(tag, 1, 4);
  endtask

  initial begin
    rst = 1'b1; wr_data = '0; wr_vld = 1'b0; frame_len = '0; start = 1'b0; signal_rdy = 1'b1;
    m_busy = 1'b0; m_rem = 0; m_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    tick();

    // Basic 4-sample frame
    basic_frame("basic");

    // Backpressure on 2nd and 3rd SEND cycles holds sample 2
    load_seq(1, 4);
    got.delete();
    start_frame(4);
    tick();
    signal_rdy = 1'b0;
    repeat (2) tick();
    signal_rdy = 1'b1;
    repeat (5) tick();
    check_got("bp", 1, 4);

    // Underrun bubble in a 10-sample frame
    got.delete();
    start_frame(10);
    load_seq(1, 4);
    repeat (2) tick();
    check_val("bubble_vld", 32'(signal_vld), 32'd0);
    load_seq(5, 6);
    repeat (4) tick();
    check_got("underrun", 1, 10);

    // Fill past full, then drain a 16-sample frame
    load_seq(100, 17);
    check_val("full_count", 32'(fifo_count), 32'(DEPTH));
    check_val("full_rdy", 32'(wr_rdy), 32'd0);
    got.delete();
    start_frame(16);
    tick();
    tick();
    check_val("rdy_after_xfer", 32'(wr_rdy), 32'd1);
    repeat (18) tick();
    check_got("full", 100, 16);

    // Zero-length start is ignored
    done_pulses = 0;
    start_frame(0);
    repeat (3) tick();
    check_val("zero_len_done", 32'(done_pulses), 32'd0);

    // Start during SEND does not change the frame length
    load_seq(50, 6);
    got.delete();
    signal_rdy = 1'b0;
    start_frame(3);
    start_frame(6);
    signal_rdy = 1'b1;
    repeat (6) tick();
    check_got("restart", 50, 3);
    repeat (5) tick();
    got.delete();

    // Reset after two of four samples
    load_seq(1, 4);
    start_frame(4);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_vld", 32'(signal_vld), 32'd0);
    check_val("rst_count", 32'(fifo_count), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    tick();
    basic_frame("post_rst");

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      wr_vld     = ($urandom_range(0, 99) < 60);
      wr_data    = DW'($urandom);
      signal_rdy = ($urandom_range(0, 99) < 70);
      start      = ($urandom_range(0, 99) < 10);
      frame_len  = LW'($urandom_range(0, 20));
      rst        = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 1'b0; start = 1'b0; wr_vld = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
